// File: rtl/v4_tagged_deque.sv
// v4_tagged_deque
//   Tagged double-ended queue with integrated entry storage, a lowest-free
//   tag allocator and a p_srch_lanes-wide tag search engine. A single
//   val/rdy opcode request channel and a single val/rdy response channel
//   carry every operation; at most one operation is in flight.
//
// Build option:
//   V4_TAGGED_DEQUE_PEEK_EN  when defined, op 6 (PEEK) searches for the tag
//                            and returns its data; when undefined, op 6 is
//                            answered with BADOP one cycle after acceptance.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_val/req_rdy   request handshake
//   req_op            0 ENQ_BACK 1 ENQ_FRONT 2 DEQ_FRONT 3 DEQ_BACK
//                     4 UPD 5 DEL 6 PEEK 7 reserved
//   req_tag           target tag for UPD/DEL/PEEK
//   req_data          write data for ENQ_* and UPD
//   rsp_val/rsp_rdy   response handshake
//   rsp_op            echoed opcode
//   rsp_status        0 OK 1 FULL 2 EMPTY 3 NOT_FOUND 4 BADOP
//   rsp_tag           issued tag (ENQ_*) or removed/target tag
//   rsp_data          dequeued, deleted, pre-update or peeked data
//   count/empty/full  occupancy and flags
module v4_tagged_deque #(
  parameter int unsigned p_depth      = 32,
  parameter int unsigned p_chanwidth  = 32,
  parameter int unsigned p_srch_lanes = 4,
  parameter int unsigned p_ptrwidth   = $clog2(p_depth),
  parameter int unsigned p_cntwidth   = $clog2(p_depth + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic [2:0]             req_op,
  input  logic [p_ptrwidth-1:0]  req_tag,
  input  logic [p_chanwidth-1:0] req_data,
  output logic                   rsp_val,
  input  logic                   rsp_rdy,
  output logic [2:0]             rsp_op,
  output logic [2:0]             rsp_status,
  output logic [p_ptrwidth-1:0]  rsp_tag,
  output logic [p_chanwidth-1:0] rsp_data,
  output logic [p_cntwidth-1:0]  count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned p_groups = p_depth / p_srch_lanes;
  localparam int unsigned p_gw     = (p_groups > 1) ? $clog2(p_groups) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SRCH, S_RSP} state_e;

  typedef enum logic [2:0] {
    OP_ENQ_BACK  = 3'd0,
    OP_ENQ_FRONT = 3'd1,
    OP_DEQ_FRONT = 3'd2,
    OP_DEQ_BACK  = 3'd3,
    OP_UPD       = 3'd4,
    OP_DEL       = 3'd5,
    OP_PEEK      = 3'd6,
    OP_RSVD      = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_OK        = 3'd0,
    ST_FULL      = 3'd1,
    ST_EMPTY     = 3'd2,
    ST_NOT_FOUND = 3'd3,
    ST_BADOP     = 3'd4
  } status_e;

  state_e state_q, state_d;

  // Entry storage; entries at index >= count are don't-care, so no reset.
  logic [p_ptrwidth-1:0]  tag_q  [p_depth];
  logic [p_ptrwidth-1:0]  tag_d  [p_depth];
  logic [p_chanwidth-1:0] data_q [p_depth];
  logic [p_chanwidth-1:0] data_d [p_depth];

  logic [p_cntwidth-1:0]  count_q, count_d;
  logic [p_depth-1:0]     free_q, free_d;

  op_e                    lat_op_q, lat_op_d;
  logic [p_ptrwidth-1:0]  lat_tag_q, lat_tag_d;
  logic [p_chanwidth-1:0] lat_data_q, lat_data_d;

  // Search pipeline: group under compare, registered hit/miss verdict.
  logic [p_gw-1:0]        grp_q, grp_d;
  logic                   hit_q, hit_d;
  logic                   miss_q, miss_d;
  logic [p_ptrwidth-1:0]  hidx_q, hidx_d;

  logic [2:0]             rsp_op_q, rsp_op_d;
  status_e                rsp_status_q, rsp_status_d;
  logic [p_ptrwidth-1:0]  rsp_tag_q, rsp_tag_d;
  logic [p_chanwidth-1:0] rsp_data_q, rsp_data_d;

  logic                   full_w, empty_w;
  logic                   req_is_srch;
  logic [p_ptrwidth-1:0]  alloc_tag;
  logic                   lane_hit;
  logic [p_ptrwidth-1:0]  lane_idx;
  logic                   last_grp;

  assign full_w  = (count_q == p_cntwidth'(p_depth));
  assign empty_w = (count_q == '0);

  always_comb begin
    req_is_srch = (req_op == OP_UPD) || (req_op == OP_DEL);
`ifdef V4_TAGGED_DEQUE_PEEK_EN
    req_is_srch = req_is_srch || (req_op == OP_PEEK);
`endif
  end

  // Lowest free tag; scanning downward lets the lowest index win.
  always_comb begin
    alloc_tag = '0;
    for (int unsigned i = p_depth; i > 0; i--) begin
      if (free_q[i-1]) alloc_tag = p_ptrwidth'(i - 1);
    end
  end

  // Compare the p_srch_lanes entries of the current group against the
  // latched tag; only indices below count take part.
  always_comb begin
    lane_hit = 1'b0;
    lane_idx = '0;
    last_grp = 1'b0;
    for (int unsigned g = 0; g < p_groups; g++) begin
      if (grp_q == p_gw'(g)) begin
        last_grp = (p_cntwidth'((g + 1) * p_srch_lanes) >= count_q);
        for (int unsigned j = 0; j < p_srch_lanes; j++) begin
          // Walk lanes from high to low so the lowest matching index wins.
          if ((p_cntwidth'(g * p_srch_lanes + (p_srch_lanes - 1 - j)) < count_q) &&
              (tag_q[g * p_srch_lanes + (p_srch_lanes - 1 - j)] == lat_tag_q)) begin
            lane_hit = 1'b1;
            lane_idx = p_ptrwidth'(g * p_srch_lanes + (p_srch_lanes - 1 - j));
          end
        end
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_val) state_d = (req_is_srch && !empty_w) ? S_SRCH : S_RSP;
      S_SRCH: if (hit_q || miss_q) state_d = S_RSP;
      S_RSP:  if (rsp_rdy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_rdy    = (state_q == S_IDLE) && !rst;
    rsp_val    = (state_q == S_RSP);
    rsp_op     = rsp_op_q;
    rsp_status = rsp_status_q;
    rsp_tag    = rsp_tag_q;
    rsp_data   = rsp_data_q;
    count      = count_q;
    empty      = empty_w;
    full       = full_w;
  end

  // Datapath next state
  always_comb begin
    tag_d        = tag_q;
    data_d       = data_q;
    count_d      = count_q;
    free_d       = free_q;
    lat_op_d     = lat_op_q;
    lat_tag_d    = lat_tag_q;
    lat_data_d   = lat_data_q;
    grp_d        = grp_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    hidx_d       = hidx_q;
    rsp_op_d     = rsp_op_q;
    rsp_status_d = rsp_status_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_data_d   = rsp_data_q;

    case (state_q)
      S_IDLE: begin
        if (req_val) begin
          lat_op_d     = op_e'(req_op);
          lat_tag_d    = req_tag;
          lat_data_d   = req_data;
          grp_d        = '0;
          hit_d        = 1'b0;
          miss_d       = 1'b0;
          rsp_op_d     = req_op;
          rsp_tag_d    = req_tag;
          rsp_data_d   = '0;
          rsp_status_d = ST_OK;
          case (op_e'(req_op))
            OP_ENQ_BACK: begin
              if (full_w) rsp_status_d = ST_FULL;
              else begin
                for (int unsigned i = 0; i < p_depth; i++) begin
                  if (p_cntwidth'(i) == count_q) begin
                    tag_d[i]  = alloc_tag;
                    data_d[i] = req_data;
                  end
                end
                free_d[alloc_tag] = 1'b0;
                count_d           = count_q + p_cntwidth'(1);
                rsp_tag_d         = alloc_tag;
              end
            end
            OP_ENQ_FRONT: begin
              if (full_w) rsp_status_d = ST_FULL;
              else begin
                for (int unsigned i = 1; i < p_depth; i++) begin
                  tag_d[i]  = tag_q[i-1];
                  data_d[i] = data_q[i-1];
                end
                tag_d[0]          = alloc_tag;
                data_d[0]         = req_data;
                free_d[alloc_tag] = 1'b0;
                count_d           = count_q + p_cntwidth'(1);
                rsp_tag_d         = alloc_tag;
              end
            end
            OP_DEQ_FRONT: begin
              if (empty_w) rsp_status_d = ST_EMPTY;
              else begin
                rsp_tag_d  = tag_q[0];
                rsp_data_d = data_q[0];
                for (int unsigned i = 0; i + 1 < p_depth; i++) begin
                  tag_d[i]  = tag_q[i+1];
                  data_d[i] = data_q[i+1];
                end
                free_d[tag_q[0]] = 1'b1;
                count_d          = count_q - p_cntwidth'(1);
              end
            end
            OP_DEQ_BACK: begin
              if (empty_w) rsp_status_d = ST_EMPTY;
              else begin
                for (int unsigned i = 0; i < p_depth; i++) begin
                  if (p_cntwidth'(i + 1) == count_q) begin
                    rsp_tag_d        = tag_q[i];
                    rsp_data_d       = data_q[i];
                    free_d[tag_q[i]] = 1'b1;
                  end
                end
                count_d = count_q - p_cntwidth'(1);
              end
            end
            OP_UPD, OP_DEL: begin
              if (empty_w) rsp_status_d = ST_EMPTY;
            end
`ifdef V4_TAGGED_DEQUE_PEEK_EN
            OP_PEEK: begin
              if (empty_w) rsp_status_d = ST_EMPTY;
            end
`endif
            default: rsp_status_d = ST_BADOP;
          endcase
        end
      end

      S_SRCH: begin
        // The hit/miss verdict of a group is registered and acted on one
        // cycle later, so the queue is only modified from registered state.
        if (hit_q) begin
          rsp_status_d = ST_OK;
          rsp_tag_d    = lat_tag_q;
          rsp_data_d   = data_q[hidx_q];
          case (lat_op_q)
            OP_UPD: data_d[hidx_q] = lat_data_q;
            OP_DEL: begin
              for (int unsigned i = 0; i + 1 < p_depth; i++) begin
                if (p_ptrwidth'(i) >= hidx_q) begin
                  tag_d[i]  = tag_q[i+1];
                  data_d[i] = data_q[i+1];
                end
              end
              free_d[lat_tag_q] = 1'b1;
              count_d           = count_q - p_cntwidth'(1);
            end
            default: ;
          endcase
        end else if (miss_q) begin
          rsp_status_d = ST_NOT_FOUND;
          rsp_tag_d    = lat_tag_q;
          rsp_data_d   = '0;
        end else begin
          hit_d  = lane_hit;
          hidx_d = lane_idx;
          miss_d = !lane_hit && last_grp;
          grp_d  = grp_q + p_gw'(1);
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      free_q       <= '1;
      lat_op_q     <= OP_ENQ_BACK;
      lat_tag_q    <= '0;
      lat_data_q   <= '0;
      grp_q        <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      hidx_q       <= '0;
      rsp_op_q     <= '0;
      rsp_status_q <= ST_OK;
      rsp_tag_q    <= '0;
      rsp_data_q   <= '0;
    end else begin
      count_q      <= count_d;
      free_q       <= free_d;
      lat_op_q     <= lat_op_d;
      lat_tag_q    <= lat_tag_d;
      lat_data_q   <= lat_data_d;
      grp_q        <= grp_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      hidx_q       <= hidx_d;
      rsp_op_q     <= rsp_op_d;
      rsp_status_q <= rsp_status_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_v4_tagged_deque.sv
// Directed testbench for v4_tagged_deque with p_depth=8, p_srch_lanes=2.
module tb_v4_tagged_deque;

  logic        clk;
  logic        rst;
  logic        req_val;
  logic        req_rdy;
  logic [2:0]  req_op;
  logic [2:0]  req_tag;
  logic [31:0] req_data;
  logic        rsp_val;
  logic        rsp_rdy;
  logic [2:0]  rsp_op;
  logic [2:0]  rsp_status;
  logic [2:0]  rsp_tag;
  logic [31:0] rsp_data;
  logic [3:0]  count;
  logic        empty;
  logic        full;

  int checks = 0;
  int errors = 0;

  // Last captured response
  int          r_lat;
  logic [2:0]  r_op;
  logic [2:0]  r_st;
  logic [2:0]  r_tag;
  logic [31:0] r_data;
  logic [3:0]  r_cnt;
  logic        r_full;
  logic        r_empty;

  v4_tagged_deque #(
    .p_depth     (8),
    .p_chanwidth (32),
    .p_srch_lanes(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_op    (req_op),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .rsp_val   (rsp_val),
    .rsp_rdy   (rsp_rdy),
    .rsp_op    (rsp_op),
    .rsp_status(rsp_status),
    .rsp_tag   (rsp_tag),
    .rsp_data  (rsp_data),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; req_val = 1'b0; rsp_rdy = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one request, measure cycles from the accepting edge to rsp_val,
  // capture the response, then pop it.
  task automatic issue(input logic [2:0] op, input logic [2:0] tag, input logic [31:0] data);
    int k;
    r_lat = -1;
    @(negedge clk);
    req_val = 1'b1; req_op = op; req_tag = tag; req_data = data;
    k = 0;
    while (!req_rdy && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
    req_val = 1'b0; req_tag = 3'd7; req_data = 32'hDEAD_BEEF;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (rsp_val) begin
        r_lat = n;
        break;
      end
    end
    r_op = rsp_op; r_st = rsp_status; r_tag = rsp_tag; r_data = rsp_data;
    r_cnt = count; r_full = full; r_empty = empty;
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    rsp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_val = 1'b0; rsp_rdy = 1'b0;
    req_op = '0; req_tag = '0; req_data = '0;
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (req_rdy !== 1'b0 || rsp_val !== 1'b0) begin
      errors++; $display("FAIL reset_hs got req_rdy=%0b rsp_val=%0b exp 0 0", req_rdy, rsp_val);
    end
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL reset_occ got count=%0d empty=%0b full=%0b exp 0 1 0", count, empty, full);
    end
    checks++;
    if (rsp_op !== 3'd0 || rsp_status !== 3'd0 || rsp_tag !== 3'd0 || rsp_data !== 32'd0) begin
      errors++; $display("FAIL reset_rsp got op=%0d st=%0d tag=%0d data=%h exp all 0", rsp_op, rsp_status, rsp_tag, rsp_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_rdy !== 1'b1) begin
      errors++; $display("FAIL reset_release got req_rdy=%0b exp 1", req_rdy);
    end
  endtask

  task automatic test_enq_front();
    issue(3'd0, 3'd0, 32'hA);
    checks++;
    if (r_st !== 3'd0 || r_tag !== 3'd0 || r_lat !== 1 || r_op !== 3'd0 || r_cnt !== 4'd1) begin
      errors++; $display("FAIL enq_a got st=%0d tag=%0d lat=%0d op=%0d cnt=%0d exp 0 0 1 0 1", r_st, r_tag, r_lat, r_op, r_cnt);
    end
    issue(3'd0, 3'd0, 32'hB);
    checks++;
    if (r_st !== 3'd0 || r_tag !== 3'd1) begin
      errors++; $display("FAIL enq_b got st=%0d tag=%0d exp 0 1", r_st, r_tag);
    end
    issue(3'd1, 3'd0, 32'hC);
    checks++;
    if (r_st !== 3'd0 || r_tag !== 3'd2 || r_cnt !== 4'd3 || r_op !== 3'd1) begin
      errors++; $display("FAIL enqf_c got st=%0d tag=%0d cnt=%0d op=%0d exp 0 2 3 1", r_st, r_tag, r_cnt, r_op);
    end
    issue(3'd2, 3'd0, 32'h0);
    checks++;
    if (r_st !== 3'd0 || r_tag !== 3'd2 || r_data !== 32'hC || r_cnt !== 4'd2) begin
      errors++; $display("FAIL deqf_1 got st=%0d tag=%0d data=%h cnt=%0d exp 0 2 c 2", r_st, r_tag, r_data, r_cnt);
    end
    issue(3'd2, 3'd0, 32'h0);
    checks++;
    if (r_st !== 3'd0 || r_tag !== 3'd0 || r_data !== 32'hA || r_cnt !== 4'd1) begin
      errors++; $display("FAIL deqf_2 got st=%0d tag=%0d data=%h cnt=%0d exp 0 0 a 1", r_st, r_tag, r_data, r_cnt);
    end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      issue(3'd0, 3'd0, 32'h100 + i);
      checks++;
      if (r_st !== 3'd0 || r_tag !== 3'(i)) begin
        errors++; $display("FAIL fill_%0d got st=%0d tag=%0d exp 0 %0d", i, r_st, r_tag, i);
      end
    end
    issue(3'd0, 3'd5, 32'h999);
    checks++;
    if (r_st !== 3'd1 || r_tag !== 3'd5 || r_data !== 32'd0 || r_cnt !== 4'd8 || r_full !== 1'b1 || r_lat !== 1) begin
      errors++; $display("FAIL enq_full got st=%0d tag=%0d data=%h cnt=%0d full=%0b lat=%0d exp 1 5 0 8 1 1", r_st, r_tag, r_data, r_cnt, r_full, r_lat);
    end
    issue(3'd3, 3'd0, 32'h0);
    checks++;
    if (r_st !== 3'd0 || r_tag !== 3'd7 || r_data !== 32'h107 || r_cnt !== 4'd7) begin
      errors++; $display("FAIL deqb got st=%0d tag=%0d data=%h cnt=%0d exp 0 7 107 7", r_st, r_tag, r_data, r_cnt);
    end
    issue(3'd0, 3'd0, 32'h200);
    checks++;
    if (r_st !== 3'd0 || r_tag !== 3'd7 || r_cnt !== 4'd8) begin
      errors++; $display("FAIL reissue_tag got st=%0d tag=%0d cnt=%0d exp 0 7 8", r_st, r_tag, r_cnt);
    end
  endtask

  // Queue holds tags 0..7 in order (tag 7 carries 0x200).
  task automatic test_del();
    issue(3'd5, 3'd6, 32'h0);
    checks++;
    if (r_st !== 3'd0 || r_tag !== 3'd6 || r_data !== 32'h106 || r_cnt !== 4'd7 || r_lat !== 5 || r_op !== 3'd5) begin
      errors++; $display("FAIL del6 got st=%0d tag=%0d data=%h cnt=%0d lat=%0d op=%0d exp 0 6 106 7 5 5", r_st, r_tag, r_data, r_cnt, r_lat, r_op);
    end
    issue(3'd5, 3'd6, 32'h0);
    checks++;
    if (r_st !== 3'd3 || r_tag !== 3'd6 || r_data !== 32'd0 || r_cnt !== 4'd7 || r_lat !== 5) begin
      errors++; $display("FAIL del6_nf got st=%0d tag=%0d data=%h cnt=%0d lat=%0d exp 3 6 0 7 5", r_st, r_tag, r_data, r_cnt, r_lat);
    end
    issue(3'd5, 3'd0, 32'h0);
    checks++;
    if (r_st !== 3'd0 || r_tag !== 3'd0 || r_data !== 32'h100 || r_cnt !== 4'd6 || r_lat !== 2) begin
      errors++; $display("FAIL del0 got st=%0d tag=%0d data=%h cnt=%0d lat=%0d exp 0 0 100 6 2", r_st, r_tag, r_data, r_cnt, r_lat);
    end
    issue(3'd3, 3'd0, 32'h0);
    checks++;
    if (r_st !== 3'd0 || r_tag !== 3'd7 || r_data !== 32'h200 || r_cnt !== 4'd5) begin
      errors++; $display("FAIL del_back got st=%0d tag=%0d data=%h cnt=%0d exp 0 7 200 5", r_st, r_tag, r_data, r_cnt);
    end
    issue(3'd2, 3'd0, 32'h0);
    checks++;
    if (r_st !== 3'd0 || r_tag !== 3'd1 || r_data !== 32'h101 || r_cnt !== 4'd4) begin
      errors++; $display("FAIL del_front got st=%0d tag=%0d data=%h cnt=%0d exp 0 1 101 4", r_st, r_tag, r_data, r_cnt);
    end
  endtask

  task automatic test_upd();
    apply_reset();
    issue(3'd0, 3'd0, 32'h10);
    issue(3'd0, 3'd0, 32'h11);
    issue(3'd0, 3'd0, 32'h12);
    issue(3'd4, 3'd1, 32'h55);
    checks++;
    if (r_st !== 3'd0 || r_tag !== 3'd1 || r_data !== 32'h11 || r_cnt !== 4'd3 || r_lat !== 2 || r_op !== 3'd4) begin
      errors++; $display("FAIL upd1 got st=%0d tag=%0d data=%h cnt=%0d lat=%0d op=%0d exp 0 1 11 3 2 4", r_st, r_tag, r_data, r_cnt, r_lat, r_op);
    end
    issue(3'd2, 3'd0, 32'h0);
    checks++;
    if (r_tag !== 3'd0 || r_data !== 32'h10) begin
      errors++; $display("FAIL upd_deq0 got tag=%0d data=%h exp 0 10", r_tag, r_data);
    end
    issue(3'd2, 3'd0, 32'h0);
    checks++;
    if (r_st !== 3'd0 || r_tag !== 3'd1 || r_data !== 32'h55) begin
      errors++; $display("FAIL upd_deq1 got st=%0d tag=%0d data=%h exp 0 1 55", r_st, r_tag, r_data);
    end
    issue(3'd2, 3'd0, 32'h0);
    checks++;
    if (r_tag !== 3'd2 || r_data !== 32'h12 || r_cnt !== 4'd0 || r_empty !== 1'b1) begin
      errors++; $display("FAIL upd_deq2 got tag=%0d data=%h cnt=%0d empty=%0b exp 2 12 0 1", r_tag, r_data, r_cnt, r_empty);
    end
    issue(3'd4, 3'd1, 32'h66);
    checks++;
    if (r_st !== 3'd2 || r_tag !== 3'd1 || r_data !== 32'd0 || r_lat !== 1) begin
      errors++; $display("FAIL upd_empty got st=%0d tag=%0d data=%h lat=%0d exp 2 1 0 1", r_st, r_tag, r_data, r_lat);
    end
    issue(3'd3, 3'd4, 32'h0);
    checks++;
    if (r_st !== 3'd2 || r_tag !== 3'd4 || r_cnt !== 4'd0 || r_lat !== 1) begin
      errors++; $display("FAIL deqb_empty got st=%0d tag=%0d cnt=%0d lat=%0d exp 2 4 0 1", r_st, r_tag, r_cnt, r_lat);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    issue(3'd0, 3'd0, 32'h77);
    @(negedge clk);
    req_val = 1'b1; req_op = 3'd2; req_tag = 3'd3; req_data = 32'h0;
    @(posedge clk); #1;
    req_val = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (rsp_val !== 1'b1 || req_rdy !== 1'b0 || rsp_op !== 3'd2 || rsp_status !== 3'd0 ||
          rsp_tag !== 3'd0 || rsp_data !== 32'h77 || count !== 4'd0) begin
        errors++;
        $display("FAIL stall_%0d got val=%0b rdy=%0b op=%0d st=%0d tag=%0d data=%h cnt=%0d exp 1 0 2 0 0 77 0",
                 c, rsp_val, req_rdy, rsp_op, rsp_status, rsp_tag, rsp_data, count);
      end
      if (c < 5) begin
        @(posedge clk); #1;
      end
    end
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    rsp_rdy = 1'b0;
    checks++;
    if (rsp_val !== 1'b0 || req_rdy !== 1'b1) begin
      errors++; $display("FAIL stall_release got val=%0b rdy=%0b exp 0 1", rsp_val, req_rdy);
    end
  endtask

  task automatic test_rst_srch();
    apply_reset();
    for (int i = 0; i < 4; i++) issue(3'd0, 3'd0, 32'h40 + i);
    @(negedge clk);
    req_val = 1'b1; req_op = 3'd5; req_tag = 3'd0; req_data = 32'h0;
    @(posedge clk); #1;
    req_val = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp_val !== 1'b0 || req_rdy !== 1'b0 || count !== 4'd4) begin
      errors++; $display("FAIL srch_busy got val=%0b rdy=%0b cnt=%0d exp 0 0 4", rsp_val, req_rdy, count);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_val !== 1'b0 || count !== 4'd0 || empty !== 1'b1 || req_rdy !== 1'b0) begin
      errors++; $display("FAIL rst_srch got val=%0b cnt=%0d empty=%0b rdy=%0b exp 0 0 1 0", rsp_val, count, empty, req_rdy);
    end
    @(negedge clk);
    rst = 1'b0;
    issue(3'd0, 3'd0, 32'h99);
    checks++;
    if (r_st !== 3'd0 || r_tag !== 3'd0 || r_cnt !== 4'd1) begin
      errors++; $display("FAIL rst_first_tag got st=%0d tag=%0d cnt=%0d exp 0 0 1", r_st, r_tag, r_cnt);
    end
  endtask

  task automatic test_peek();
    apply_reset();
    for (int i = 0; i < 4; i++) issue(3'd0, 3'd0, 32'h30 + i);
    issue(3'd6, 3'd3, 32'h0);
`ifdef V4_TAGGED_DEQUE_PEEK_EN
    checks++;
    if (r_st !== 3'd0 || r_tag !== 3'd3 || r_data !== 32'h33 || r_cnt !== 4'd4 || r_lat !== 3 || r_op !== 3'd6) begin
      errors++; $display("FAIL peek3 got st=%0d tag=%0d data=%h cnt=%0d lat=%0d op=%0d exp 0 3 33 4 3 6", r_st, r_tag, r_data, r_cnt, r_lat, r_op);
    end
    issue(3'd6, 3'd5, 32'h0);
    checks++;
    if (r_st !== 3'd3 || r_tag !== 3'd5 || r_data !== 32'd0 || r_cnt !== 4'd4 || r_lat !== 3) begin
      errors++; $display("FAIL peek_nf got st=%0d tag=%0d data=%h cnt=%0d lat=%0d exp 3 5 0 4 3", r_st, r_tag, r_data, r_cnt, r_lat);
    end
`else
    checks++;
    if (r_st !== 3'd4 || r_tag !== 3'd3 || r_data !== 32'd0 || r_cnt !== 4'd4 || r_lat !== 1 || r_op !== 3'd6) begin
      errors++; $display("FAIL peek_badop got st=%0d tag=%0d data=%h cnt=%0d lat=%0d op=%0d exp 4 3 0 4 1 6", r_st, r_tag, r_data, r_cnt, r_lat, r_op);
    end
`endif
    issue(3'd7, 3'd2, 32'h1234);
    checks++;
    if (r_st !== 3'd4 || r_tag !== 3'd2 || r_data !== 32'd0 || r_cnt !== 4'd4 || r_lat !== 1 || r_op !== 3'd7) begin
      errors++; $display("FAIL op7 got st=%0d tag=%0d data=%h cnt=%0d lat=%0d op=%0d exp 4 2 0 4 1 7", r_st, r_tag, r_data, r_cnt, r_lat, r_op);
    end
    issue(3'd2, 3'd0, 32'h0);
    checks++;
    if (r_st !== 3'd0 || r_tag !== 3'd0 || r_data !== 32'h30 || r_cnt !== 4'd3) begin
      errors++; $display("FAIL peek_unchanged got st=%0d tag=%0d data=%h cnt=%0d exp 0 0 30 3", r_st, r_tag, r_data, r_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_enq_front();
    test_full();
    test_del();
    test_upd();
    test_stall();
    test_rst_srch();
    test_peek();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/v4_tagged_deque.md
# v4_tagged_deque

Parametrised tagged double-ended queue with integrated entry storage, tag allocator and a multi-lane tag search engine. Replaces the split per-operation req/cpl control of the previous generation with a single opcode request channel and a single response channel, both val/rdy. Every entry carries a controller-issued tag, so clients can update, delete or peek at an entry anywhere in the queue. The block sits between operation-centric queue clients and downstream consumers as a self-contained queue.

## Interface
- p_depth, 32, number of entries (≥2, power of two)
- p_chanwidth, 32, data width
- p_srch_lanes, 4, entries compared per search cycle (divides p_depth)
- p_ptrwidth, $clog2(p_depth), tag width
- p_cntwidth, $clog2(p_depth+1), occupancy width

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- req_val  in  1  request valid
- req_rdy  out  1  request ready
- req_op  in  3  0 ENQ_BACK, 1 ENQ_FRONT, 2 DEQ_FRONT, 3 DEQ_BACK, 4 UPD, 5 DEL, 6 PEEK, 7 reserved
- req_tag  in  p_ptrwidth  target tag (UPD/DEL/PEEK)
- req_data  in  p_chanwidth  write data (ENQ_*/UPD)
- rsp_val  out  1  response valid
- rsp_rdy  in  1  response ready
- rsp_op  out  3  echoed opcode
- rsp_status  out  3  0 OK, 1 FULL, 2 EMPTY, 3 NOT_FOUND, 4 BADOP
- rsp_tag  out  p_ptrwidth  issued tag (ENQ_*) or removed/target tag
- rsp_data  out  p_chanwidth  dequeued, deleted, old (UPD) or peeked data
- count  out  p_cntwidth  occupancy
- empty  out  1  count==0
- full  out  1  count==p_depth

## Operation
- Storage: entries [0..count-1], front at index 0. Each entry is {tag, data}. Entries at index ≥ count are don't-care.
- Tag allocator: a free bitmask, all ones at reset. ENQ_* issues the lowest free tag and clears its bit. DEQ_* and DEL set the bit of the removed tag.
- FSM states IDLE, SRCH, RSP.
  - IDLE: req_rdy=1. On req_val, the request is latched. UPD/DEL/PEEK with count>0 go to SRCH. All other requests execute immediately and go to RSP.
  - SRCH: each cycle compares lanes [g*L, g*L+L-1] (L = p_srch_lanes) with index < count against the latched tag; g starts at 0.
    - On a hit, the lowest matching index executes the op and the FSM goes to RSP with OK.
    - If no hit by the last group covering count-1, the FSM goes to RSP with NOT_FOUND and the queue is unchanged.
  - RSP: rsp_val=1 and all rsp_* are held stable. rsp_val && rsp_rdy returns the FSM to IDLE.
- ENQ_BACK writes index count. ENQ_FRONT shifts [0..count-1] up by one and writes index 0. Both increment count.
- DEQ_FRONT returns index 0 and shifts the rest down. DEQ_BACK returns index count-1. Both decrement count.
- UPD overwrites data (tag unchanged) and returns the old data. DEL returns the data and shifts entries above the hit index down by one, decrementing count. PEEK returns the data and leaves the queue unchanged.
- Error cases leave the queue and allocator unchanged:
  - ENQ_* when full: FULL.
  - DEQ_*/UPD/DEL/PEEK when empty: EMPTY, with no SRCH.
  - Opcode 7: BADOP.
- Non-OK responses drive rsp_tag=req_tag and rsp_data=0.

## Timing
- Reset values: req_rdy=0 while rst is high; rsp_val=0; rsp_op, rsp_status, rsp_tag, rsp_data, count all 0; empty=1; full=0; state IDLE; allocator all free. rst dominates in any state and aborts an in-flight search or a pending response without completing it.
- Non-search op accepted at edge N: state change is visible at N+1 and rsp_val is high from N+1.
- Search op accepted at N with a hit in group g: rsp_val goes high at N+2+g. Not found: rsp_val goes high at N+1+ceil(count/L).
- count, empty and full update on the same edge that enters RSP.
- req_rdy=0 in SRCH and RSP; there is at most one operation in flight.
- Best-case throughput is one op per 2 cycles, reached when rsp_rdy is held high.
- req_tag and req_data are sampled only at acceptance.

## Configuration
- V4_TAGGED_DEQUE_PEEK_EN
  - Defined: PEEK (op 6) is supported as described above.
  - Undefined: op 6 responds BADOP one cycle after acceptance, with no search and no state change. The PEEK datapath is not built.

## Test plan
- Parameters for all scenarios: p_depth=8, p_srch_lanes=2.
- Reset, ENQ_BACK 0xA, ENQ_BACK 0xB, ENQ_FRONT 0xC → tags 0,1,2 with OK; count=3; DEQ_FRONT returns 0xC tag 2, then 0xA tag 0.
- Fill with 8 ENQ_BACK → 9th ENQ_BACK gives FULL with count=8. DEQ_BACK returns entry 7 (tag 7). Next ENQ_BACK is issued tag 7.
- 8 entries with tags 0..7 in order: DEL tag 6 → rsp_val 5 cycles after accept, OK, returns data of tag 6, count=7. DEL tag 6 again → NOT_FOUND after 4 SRCH cycles.
- UPD tag 1 with 0x55 on a queue holding tag 1=0x11 → OK with rsp_data=0x11. A following DEQ returns 0x55 when tag 1 reaches the front.
- Hold rsp_rdy=0 for 5 cycles during RSP → rsp_* stable and req_rdy=0 throughout. Assert rst during SRCH → next cycle rsp_val=0, count=0, empty=1. First ENQ after reset is issued tag 0.
- PEEK tag 3 with macro defined → OK, data returned, count unchanged. Without macro → BADOP 1 cycle after accept. Opcode 7 → BADOP.
